// File: rtl/u_rca24_pkg.sv
// Shared types and widths for the streaming 24-bit ripple-carry accumulator.
// The result struct is sized by the default carry-extension and counter widths.
package u_rca24_pkg;
  localparam int RCA_W       = 24;
  localparam int RCA_OUT_W   = 25;
  localparam int DEF_CARRY_W = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int RES_SUM_W   = RCA_W + DEF_CARRY_W;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  typedef struct packed {
    logic [RES_SUM_W-1:0] sum;
    logic [DEF_CNT_W-1:0] cnt;
    logic                 ovf;
  } result_t;
endpackage

// File: rtl/u_rca24_acc_stream_if.sv
// Operand stream in, packet result out, bundled for the accumulator.
// Both streams: a beat/result transfers on a rising edge where valid and ready are both 1;
// the producer holds valid and its payload until that edge, and ready may depend on state only.
interface u_rca24_acc_stream_if #(
  parameter int CARRY_W = 8,
  parameter int CNT_W   = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [23:0]           in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [24+CARRY_W-1:0] out_sum;
  logic [CNT_W-1:0]      out_cnt;
  logic                  out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/f_u_rca24.sv
// 24-bit unsigned ripple-carry adder; bit 24 of the output is the carry out.
module f_u_rca24 (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [24:0] f_u_rca24_out
);
  logic [24:0] c;

  always_comb begin
    c             = '0;
    f_u_rca24_out = '0;
    for (int i = 0; i < 24; i++) begin
      f_u_rca24_out[i] = a[i] ^ b[i] ^ c[i];
      c[i+1]           = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    f_u_rca24_out[24] = c[24];
  end
endmodule

// File: rtl/u_rca24_acc_stream.sv
// Packet accumulator: sums a stream of 24-bit operands into {carry_cnt, acc},
// counts operands, saturates on overflow and holds the result until it is taken.
module u_rca24_acc_stream
  import u_rca24_pkg::*;
#(
  parameter int CARRY_W = DEF_CARRY_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  u_rca24_acc_stream_if.slave  bus,
  output state_e               dbg_state
);
  state_e               state_q, state_d;
  logic [RCA_W-1:0]     acc_q, acc_d;
  logic [CARRY_W-1:0]   carry_q, carry_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  result_t              res_q, res_d;

  logic [RCA_OUT_W-1:0] add_out;
  logic                 fire;
  logic                 sat_hit;
  logic [RCA_W-1:0]     acc_nx;
  logic [CARRY_W-1:0]   carry_nx;
  logic [CNT_W-1:0]     cnt_nx;

  f_u_rca24 u_add (
    .a             (acc_q),
    .b             (bus.in_data),
    .f_u_rca24_out (add_out)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    res_d   = res_q;

    fire = bus.in_valid && (state_q == ACC);

    // Once the extension counter has nowhere to go, the total is pinned at all-ones.
    sat_hit = ovf_q || ((&carry_q) && add_out[RCA_W]);
    if (sat_hit) begin
      acc_nx   = '1;
      carry_nx = '1;
    end else begin
      acc_nx   = add_out[RCA_W-1:0];
      carry_nx = carry_q + CARRY_W'(add_out[RCA_W]);
    end
    cnt_nx = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    if (state_q == ACC) begin
      if (fire) begin
        if (bus.in_last) begin
          res_d.sum = {carry_nx, acc_nx};
          res_d.cnt = cnt_nx;
          res_d.ovf = sat_hit;
          acc_d     = '0;
          carry_d   = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          state_d   = DONE;
        end else begin
          acc_d   = acc_nx;
          carry_d = carry_nx;
          cnt_d   = cnt_nx;
          ovf_d   = sat_hit;
        end
      end
    end else begin
      if (bus.out_ready) begin
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = res_q.sum;
  assign bus.out_cnt   = res_q.cnt;
  assign bus.out_ovf   = res_q.ovf;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_u_rca24_acc_stream.sv
// Bench for u_rca24_acc_stream: directed packet table, stall/reset sequences,
// then randomized packets checked against a saturating-sum reference model.
module tb_u_rca24_acc_stream;
  import u_rca24_pkg::*;

  localparam int NPKT = 1000;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;
  int     n_chk = 0;
  int     n_err = 0;

  u_rca24_acc_stream_if #(.CARRY_W(8), .CNT_W(16)) bus ();

  u_rca24_acc_stream #(.CARRY_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [23:0] d[4];
    logic [31:0] sum;
    logic [15:0] cnt;
    logic        ovf;
    string       name;
  } vec_t;

  vec_t vecs[5];
  logic [48:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [23:0] d, input logic last);
    int w;
    w            = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && w < 200) begin
      step();
      w++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 24'($urandom);
    bus.in_last  = 1'($urandom);
  endtask

  // Result must already be valid: it is registered on the last-beat edge.
  task automatic check_result(input string name, input logic [31:0] s, input logic [15:0] c,
                              input logic o);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_sum"},   64'(bus.out_sum),   64'(s));
    chk({name, "_cnt"},   64'(bus.out_cnt),   64'(c));
    chk({name, "_ovf"},   64'(bus.out_ovf),   64'(o));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({name, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  function automatic logic [48:0] ref_model(input logic [23:0] beats[$]);
    longint unsigned total;
    int              n;
    logic            o;
    logic [31:0]     s;
    logic [15:0]     c;
    total = 0;
    n     = beats.size();
    foreach (beats[i]) total += longint'(beats[i]);
    o = (total > 64'hFFFF_FFFF);
    s = o ? 32'hFFFF_FFFF : total[31:0];
    c = (n > 65535) ? 16'hFFFF : 16'(n);
    return {s, c, o};
  endfunction

  task automatic producer();
    logic [23:0] beats[$];
    logic [23:0] d;
    int          len;
    bit          long_pkt;
    for (int p = 0; p < NPKT; p++) begin
      beats.delete();
      long_pkt = ($urandom_range(0, 49) == 0);
      len      = long_pkt ? $urandom_range(250, 300) : $urandom_range(1, 16);
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(0, 3))
          0:       d = 24'($urandom_range(0, 255));
          1:       d = 24'hFFFF00 | 24'($urandom_range(0, 255));
          default: d = 24'($urandom);
        endcase
        if (long_pkt) d = 24'hFFFF00 | 24'($urandom_range(0, 255));
        beats.push_back(d);
      end
      exp_q.push_back(ref_model(beats));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) step();
        send_beat(beats[j], (j == len - 1));
      end
    end
  endtask

  task automatic consumer();
    int          got;
    logic [48:0] e;
    got = 0;
    for (int cyc = 0; cyc < 60000 && got < NPKT; cyc++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_sum", 64'(bus.out_sum), 64'(e[48:17]));
          chk("rand_cnt", 64'(bus.out_cnt), 64'(e[16:1]));
          chk("rand_ovf", 64'(bus.out_ovf), 64'(e[0]));
        end
        got++;
      end
      step();
    end
    bus.out_ready = 1'b0;
    chk("rand_packets_received", 64'(got), 64'(NPKT));
  endtask

  initial begin
    vecs[0] = '{3, '{24'd1, 24'd2, 24'd3, 24'd0}, 32'd6, 16'd3, 1'b0, "sum123"};
    vecs[1] = '{2, '{24'hFFFFFF, 24'h000001, 24'd0, 24'd0}, 32'h0100_0000, 16'd2, 1'b0, "carry1"};
    vecs[2] = '{1, '{24'h000010, 24'd0, 24'd0, 24'd0}, 32'h10, 16'd1, 1'b0, "single"};
    vecs[3] = '{1, '{24'h000000, 24'd0, 24'd0, 24'd0}, 32'h0, 16'd1, 1'b0, "zero"};
    vecs[4] = '{4, '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, 32'h03FF_FFFC, 16'd4, 1'b0,
                "four_max"};

    do_reset();
    chk("reset_in_ready",  64'(bus.in_ready),  64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_sum",   64'(bus.out_sum),   64'd0);
    chk("reset_out_cnt",   64'(bus.out_cnt),   64'd0);
    chk("reset_out_ovf",   64'(bus.out_ovf),   64'd0);
    chk("reset_state",     64'(dbg_state),     64'(ACC));

    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++) send_beat(vecs[i].d[j], (j == vecs[i].n - 1));
      check_result(vecs[i].name, vecs[i].sum, vecs[i].cnt, vecs[i].ovf);
    end

    for (int j = 0; j < 257; j++) send_beat(24'hFFFFFF, (j == 256));
    check_result("sat257", 32'hFFFF_FFFF, 16'd257, 1'b1);

    // Stall the result for 5 cycles with a beat offered that must be ignored.
    send_beat(24'd5, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h000077;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid",    64'(bus.out_valid), 64'd1);
      chk("stall_in_ready", 64'(bus.in_ready),  64'd0);
      chk("stall_sum",      64'(bus.out_sum),   64'd5);
      chk("stall_cnt",      64'(bus.out_cnt),   64'd1);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_stall_in_ready",  64'(bus.in_ready),  64'd1);
    chk("post_stall_out_valid", 64'(bus.out_valid), 64'd0);
    send_beat(24'h10, 1'b1);
    check_result("after_stall", 32'h10, 16'd1, 1'b0);

    send_beat(24'd5, 1'b0);
    send_beat(24'd7, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    send_beat(24'd9, 1'b1);
    check_result("midrst", 32'd9, 16'd1, 1'b0);

    send_beat(24'd3, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("donerst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("donerst_out_sum",   64'(bus.out_sum),   64'd0);

    repeat (3) begin
      bus.in_data = 24'($urandom);
      bus.in_last = 1'b1;
      step();
    end
    send_beat(24'd4, 1'b1);
    check_result("idle_gap", 32'd4, 16'd1, 1'b0);

    fork
      producer();
      consumer();
    join
    chk("rand_leftover_expected", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
